multicycle_ctrl: RTL

- Multi-cycle sequencer for the 4-bit-opcode datapath: add, sub, sll, and, lw, sw, beq, plus halt.
- Shares one ALU and one unified instruction/data memory port across FETCH, DECODE, EXEC, MEM and WB phases.
- Drives PC, IR, register-file, ALU-mux and memory strobes.
- Memory access uses a req/ready handshake with a timeout watchdog.

---
 rtl/multicycle_ctrl.sv | 213 +++++++++++++++++++++
 1 files changed

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: multi-cycle sequencer for a 4-bit-opcode datapath
// (add, sub, sll, and, lw, sw, beq, halt). One ALU and one unified
// instruction/data memory port are time-shared across FETCH, DECODE, EXEC,
// MEM and WB. Memory accesses use a req/ready handshake guarded by a
// timeout watchdog that parks the sequencer in ERR.
//
// Optional feature macro: MULTICYCLE_CTRL_PERF_CNT_EN adds a 32-bit
// retired-instruction counter output (retired_cnt).
module multicycle_ctrl #(
  parameter int MEM_TIMEOUT = 15,
  parameter int TO_W        = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] opcode,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_we,
  output logic       iord,
  output logic       ir_write,
  output logic       pc_write,
  output logic       pc_src,
  output logic       tgt_write,
  output logic       reg_write,
  output logic       mem_to_reg,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [3:0] alu_ctrl,
  output logic       illegal_op,
  output logic       halted,
  output logic       bus_err,
  output logic [2:0] state
`ifdef MULTICYCLE_CTRL_PERF_CNT_EN
  ,
  output logic [31:0] retired_cnt
`endif
);

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_SLL  = 4'b0010;
  localparam logic [3:0] OP_AND  = 4'b0011;
  localparam logic [3:0] OP_LW   = 4'b0100;
  localparam logic [3:0] OP_SW   = 4'b0101;
  localparam logic [3:0] OP_BEQ  = 4'b0110;
  localparam logic [3:0] OP_HALT = 4'b1111;

  localparam logic [1:0] B_RT  = 2'b00;
  localparam logic [1:0] B_ONE = 2'b01;
  localparam logic [1:0] B_IMM = 2'b10;

  // Last wait count before the watchdog fires; unused when MEM_TIMEOUT is 0.
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(MEM_TIMEOUT - 1);
  localparam logic [TO_W-1:0] CNT_MAX = '1;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd6,
    S_ERR    = 3'd7
  } state_t;

  state_t          cur;
  state_t          nxt;
  logic [TO_W-1:0] wait_cnt;
  logic            waiting;
  logic            timeout_hit;

  assign state   = cur;
  assign waiting = ((cur == S_FETCH) || (cur == S_MEM)) && !mem_ready;
  // The watchdog only fires when ready is still low on the last allowed cycle.
  assign timeout_hit = (MEM_TIMEOUT != 0) && (wait_cnt == TO_LAST) && !mem_ready;

  // State register and memory wait counter.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (!rst_n) begin
      cur      <= S_IDLE;
      wait_cnt <= '0;
    end else begin
      cur <= nxt;
      if (nxt != cur) begin
        wait_cnt <= '0;
      end else if (waiting && (wait_cnt != CNT_MAX)) begin
        wait_cnt <= wait_cnt + 1'b1;
      end
    end
  end

  // Next-state and strobe decode from state, opcode, zero and mem_ready.
  always_comb begin
    // NOTE: every output gets a default first so no path through the case
    // leaves a signal unassigned and infers a latch.
    nxt        = cur;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    iord       = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    pc_src     = 1'b0;
    tgt_write  = 1'b0;
    reg_write  = 1'b0;
    mem_to_reg = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = B_RT;
    alu_ctrl   = OP_ADD;
    illegal_op = 1'b0;
    halted     = 1'b0;
    bus_err    = 1'b0;

    case (cur)
      S_IDLE: nxt = S_FETCH;

      S_FETCH: begin
        // Read instruction at PC while the ALU computes PC+1.
        mem_req   = 1'b1;
        alu_src_b = B_ONE;
        if (mem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          nxt      = S_DECODE;
        end else if (timeout_hit) begin
          nxt = S_ERR;
        end
      end

      S_DECODE: begin
        // Speculatively compute the branch target PC+imm.
        alu_src_b = B_IMM;
        tgt_write = 1'b1;
        if (opcode <= OP_BEQ) begin
          nxt = S_EXEC;
        end else if (opcode == OP_HALT) begin
          nxt = S_HALT;
        end else begin
          illegal_op = 1'b1;
          nxt        = S_FETCH;
        end
      end

      S_EXEC: begin
        alu_src_a = 1'b1;
        case (opcode)
          OP_ADD, OP_SUB, OP_SLL, OP_AND: begin
            alu_ctrl = opcode;
            nxt      = S_WB;
          end
          OP_LW, OP_SW: begin
            alu_src_b = B_IMM;
            nxt       = S_MEM;
          end
          OP_BEQ: begin
            alu_ctrl = OP_SUB;
            if (zero) begin
              pc_write = 1'b1;
              pc_src   = 1'b1;
            end
            nxt = S_FETCH;
          end
          default: nxt = S_FETCH;
        endcase
      end

      S_MEM: begin
        mem_req = 1'b1;
        iord    = 1'b1;
        mem_we  = (opcode == OP_SW);
        if (mem_ready) begin
          nxt = (opcode == OP_SW) ? S_FETCH : S_WB;
        end else if (timeout_hit) begin
          nxt = S_ERR;
        end
      end

      S_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = (opcode == OP_LW);
        nxt        = S_FETCH;
      end

      S_HALT: halted = 1'b1;

      S_ERR: bus_err = 1'b1;

      default: nxt = S_IDLE;
    endcase
  end

`ifdef MULTICYCLE_CTRL_PERF_CNT_EN
  logic retire;

  // An instruction retires on its final transition back to FETCH.
  assign retire = (cur == S_WB) ||
                  ((cur == S_MEM) && mem_ready && (opcode == OP_SW)) ||
                  ((cur == S_EXEC) && (opcode == OP_BEQ));

  // Free-running retired-instruction counter; wraps naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      retired_cnt <= '0;
    end else if (retire) begin
      retired_cnt <= retired_cnt + 32'd1;
    end
  end
`endif

endmodule
